// File: rtl/pc_redirect_pkg.sv
// Shared definitions for the fetch redirect producer: FSM state encoding,
// default widths and the flush window length seen by the fetch stage.
package pc_redirect_pkg;

    // Default instruction width; the PC is instSize + 8 bits wide.
    localparam int INST_SIZE_DFLT = 24;
    localparam int CNT_WIDTH_DFLT = 16;
    localparam int PC_W           = INST_SIZE_DFLT + 8;

    // Fetch samples pcWrEn through one flop, so the target and the squash
    // must stay up for that delay plus the enable cycle itself.
    localparam int FLUSH_CYCLES   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } redirect_state_t;

    // PC width for a given instruction width.
    function automatic int pc_width(input int inst_size);
        return inst_size + 8;
    endfunction

endpackage

// File: rtl/pc_redirect_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by
// the synchronous active-high clr.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = (r_cnt == {WIDTH{1'b1}});

    // Count events, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples
        // the pre-edge values of its inputs, independent of block order.
        if (clr) begin
            r_cnt <= '0;
        end else if (inc && !w_at_max) begin
            r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pc_redirect.sv
// Producer side of the fetch redirect interface. A taken branch/jump seen in
// IDLE latches its word-aligned target and runs ISSUE (pcWrEn pulse) then
// HOLD, squashing IF/ID and ID/EX in both. Control-flow results arriving in
// ISSUE/HOLD belong to the wrong path and are dropped.
module pc_redirect
    import pc_redirect_pkg::*;
#(
    parameter int instSize = INST_SIZE_DFLT,
    parameter int cntWidth = CNT_WIDTH_DFLT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  brValid,
    input  logic                  brTaken,
    input  logic [instSize+7:0]   brTarget,
    output logic                  pcWrEn,
    output logic [instSize+7:0]   newPc,
    output logic                  flushIfId,
    output logic                  flushIdEx,
    output logic                  alignErr,
    output logic [cntWidth-1:0]   redirectCnt
);

    localparam int W = instSize + 8;

    redirect_state_t r_state;
    redirect_state_t w_state_next;

    logic            w_redirect;
    logic            w_misaligned;
    logic            w_pc_wr_en_nxt;
    logic            w_flush_nxt;

    logic            r_pc_wr_en;
    logic            r_flush_if_id;
    logic            r_flush_id_ex;
    logic            r_align_err;
    logic [W-1:0]    r_tgt;

    // A redirect is only accepted while idle; later results are wrong-path.
    assign w_redirect   = (r_state == IDLE) && brValid && brTaken;
    assign w_misaligned = (brTarget[1:0] != 2'b00);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> ISSUE on a taken branch, then ISSUE -> HOLD -> IDLE.
    always_comb begin
        // NOTE: a default assignment up front keeps every path driven, so no
        // latch is inferred when a case arm forgets the signal.
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_redirect) w_state_next = ISSUE;
            ISSUE:   w_state_next = HOLD;
            HOLD:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode from the next state, so the outputs can be registered
    // and still line up with the state they belong to.
    always_comb begin
        w_pc_wr_en_nxt = 1'b0;
        w_flush_nxt    = 1'b0;
        case (w_state_next)
            ISSUE: begin
                w_pc_wr_en_nxt = 1'b1;
                w_flush_nxt    = 1'b1;
            end
            HOLD: begin
                w_flush_nxt    = 1'b1;
            end
            default: begin
                w_pc_wr_en_nxt = 1'b0;
                w_flush_nxt    = 1'b0;
            end
        endcase
    end

    // Registered control outputs toward fetch and the pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_wr_en    <= 1'b0;
            r_flush_if_id <= 1'b0;
            r_flush_id_ex <= 1'b0;
        end else begin
            r_pc_wr_en    <= w_pc_wr_en_nxt;
            r_flush_if_id <= w_flush_nxt;
            r_flush_id_ex <= w_flush_nxt;
        end
    end

    // Target latch: word-aligned copy of brTarget, held until the next redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tgt <= '0;
        end else if (w_redirect) begin
            r_tgt <= {brTarget[W-1:2], 2'b00};
        end
    end

    // Sticky misaligned-target flag; the redirect still goes to the aligned address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_align_err <= 1'b0;
        end else if (w_redirect && w_misaligned) begin
            r_align_err <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (cntWidth)
    ) u_redirect_cnt (
        .clk (clk),
        .clr (reset),
        .inc (w_redirect),
        .cnt (redirectCnt)
    );

    assign pcWrEn    = r_pc_wr_en;
    assign newPc     = r_tgt;
    assign flushIfId = r_flush_if_id;
    assign flushIdEx = r_flush_id_ex;
    assign alignErr  = r_align_err;

endmodule
